fifo_rd_drain: RTL and testbench
================================

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 SHALL have parameter data_width, default 8, the word width matching the async FIFO data path.
REQ-002 SHALL have port r_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port empty  input  1  FIFO empty flag, synchronous to r_clk.
REQ-005 SHALL have port fifo_dout  input  data_width  FIFO read data, valid exactly one r_clk cycle after the r_en pulse.
REQ-006 SHALL have port r_en  output  1  FIFO read strobe.
REQ-007 SHALL have port m_valid  output  1  stream word available.
REQ-008 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-009 SHALL have port m_data  output  data_width  stream word.
REQ-010 SHALL have port drain_cnt  output  16  count of words accepted downstream; present only under FIFO_RD_DRAIN_CNT_EN.

Function
REQ-011 SHALL convert the FIFO read port (r_en/empty, 1-cycle latency) into a valid/ready stream with no bubbles under continuous m_ready.
REQ-012 SHALL hold a 2-entry output buffer, tracked by FSM states OCC0, OCC1, OCC2 (entry count).
REQ-013 SHALL keep a 1-bit inflight flag, set in the cycle after r_en=1 and cleared otherwise.
REQ-014 SHALL assert r_en combinationally iff empty=0 and (occupancy + inflight - pop) < 2, where pop = m_valid & m_ready.
REQ-015 SHALL never assert r_en while empty=1.
REQ-016 SHALL capture fifo_dout into the buffer tail in the cycle where inflight=1.
REQ-017 SHALL drive m_valid=1 iff state is not OCC0, with m_data taken from the buffer head.
REQ-018 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-019 SHALL handle simultaneous push (inflight) and pop with no state change and the head advanced to the next entry.
REQ-020 SHALL perform state transitions: OCC0->OCC1 on push; OCC1->OCC0 on pop only; OCC1->OCC2 on push only; OCC2->OCC1 on pop; all others hold.
REQ-021 SHALL never receive a push in OCC2 without a pop; this is guaranteed by REQ-014.
REQ-022 SHALL deliver words to m_data in exact FIFO order, with no loss or duplication.
REQ-023 SHALL give a minimum latency of 2 r_clk cycles from the first r_en to m_valid=1: r_en in cycle N, capture at the end of N+1, m_valid in N+2.

Reset
REQ-024 SHALL, on rrst=1, immediately force state OCC0, inflight=0, m_valid=0, r_en=0, m_data=0, and drain_cnt=0.
REQ-025 SHALL discard buffered and in-flight words when rrst asserts mid-operation, and SHALL NOT issue r_en until the first edge after rrst deasserts.

Configuration
REQ-026 SHALL, with FIFO_RD_DRAIN_CNT_EN defined, increment drain_cnt on every pop, wrapping from 16'hFFFF to 0.
REQ-027 SHALL, without FIFO_RD_DRAIN_CNT_EN, have no drain_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-028 SHALL take the occupancy state enum (OCC0/OCC1/OCC2) and the drain_cnt width constant (16) from shared package fifo_pkg.
REQ-029 SHALL implement the 2-entry buffer as sub-module skid_buf2 (push, pop, din, dout, count); fifo_rd_drain holds the r_en/inflight control and the counter.

Verification
REQ-030 SHALL cover: rrst pulse mid-stream -> m_valid, r_en and drain_cnt all 0 within the same cycle; no r_en until after deassertion.
REQ-031 SHALL cover: FIFO preloaded with 0x01..0x08, m_ready=1 constant -> m_data 0x01..0x08 on 8 consecutive cycles, first at 2 cycles after the first r_en.
REQ-032 SHALL cover: FIFO holding 0xA5,0x5A with m_ready=0 -> exactly 2 r_en pulses, OCC2, m_data=0xA5 held stable; on m_ready=1 -> 0xA5 then 0x5A.
REQ-033 SHALL cover: empty toggling every cycle with random m_ready -> r_en never 1 while empty=1; scoreboard order matches the written order.
REQ-034 SHALL cover: FIFO_RD_DRAIN_CNT_EN defined, 65537 pops -> drain_cnt=1 (wrap), and drain_cnt equals the accepted-handshake count throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO read-drain block and its output buffer.
//   occ_state_t  - output buffer occupancy (number of words held, 0..2)
//   DRAIN_CNT_W  - width of the optional accepted-word counter
package fifo_pkg;

    localparam int DRAIN_CNT_W = 16;

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_state_t;

    // Numeric word count held in a given occupancy state.
    function automatic logic [1:0] occ_level(input occ_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: two-entry in-order word buffer with an occupancy FSM.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   push     - write din into the tail slot this cycle
//   pop      - retire the head word this cycle
//   din      - word to store
//   dout     - head word (zero after reset)
//   count    - occupancy state OCC0/OCC1/OCC2
// The caller never pushes in OCC2 without a simultaneous pop and never pops in OCC0.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dout,
    output occ_state_t            count
);

    logic [data_width-1:0] mem [2];
    logic                  head;
    logic                  tail;

    // Tail slot is head + occupancy (mod 2); in OCC2 a push only comes with a
    // pop, so it reuses the head slot that is being retired.
    always_comb begin
        tail = head ^ (count == OCC1);
    end

    assign dout = mem[head];

    // Storage, head pointer and occupancy FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            head  <= 1'b0;
            count <= OCC0;
        end else begin
            if (push) begin
                mem[tail] <= din;
            end
            if (pop) begin
                head <= ~head;
            end
            case (count)
                OCC0: begin
                    if (push) begin
                        count <= OCC1;
                    end
                end
                OCC1: begin
                    if (push && !pop) begin
                        count <= OCC2;
                    end else if (pop && !push) begin
                        count <= OCC0;
                    end
                end
                OCC2: begin
                    if (pop && !push) begin
                        count <= OCC1;
                    end
                end
                default: begin
                    count <= OCC0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: turns an async-FIFO read port (r_en/empty, read data one
// cycle after r_en) into a bubble-free valid/ready stream.
// Optional feature macro: FIFO_RD_DRAIN_CNT_EN adds the drain_cnt port and counter.
// Ports:
//   r_clk, rrst - read clock and asynchronous active-high reset
//   empty       - FIFO empty flag
//   fifo_dout   - FIFO read data (valid the cycle after r_en)
//   r_en        - FIFO read strobe (combinational)
//   m_valid, m_ready, m_data - output stream
//   drain_cnt   - words accepted downstream (only with FIFO_RD_DRAIN_CNT_EN)
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                   r_clk,
    input  logic                   rrst,
    input  logic                   empty,
    input  logic [data_width-1:0]  fifo_dout,
    output logic                   r_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [data_width-1:0]  m_data
`ifdef FIFO_RD_DRAIN_CNT_EN
    ,
    output logic [DRAIN_CNT_W-1:0] drain_cnt
`endif
);

    occ_state_t occ;
    logic       inflight;
    logic       pop;
    logic [2:0] level;

    assign m_valid = (occ != OCC0);
    assign pop     = m_valid & m_ready;

    // Issue a read only if the word it returns is guaranteed a buffer slot,
    // counting the word already in flight and the one leaving this cycle.
    // occ is OCC0 whenever pop is 0-with-empty-buffer, so level cannot underflow.
    always_comb begin
        level = {1'b0, occ_level(occ)} + {2'b00, inflight} - {2'b00, pop};
        if (!rrst && !empty && (level < 3'd2)) begin
            r_en = 1'b1;
        end else begin
            r_en = 1'b0;
        end
    end

    // Marks the cycle in which fifo_dout carries the word requested last cycle.
    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_en;
        end
    end

    skid_buf2 #(
        .data_width(data_width)
    ) u_buf (
        .clk  (r_clk),
        .rst  (rrst),
        .push (inflight),
        .pop  (pop),
        .din  (fifo_dout),
        .dout (m_data),
        .count(occ)
    );

`ifdef FIFO_RD_DRAIN_CNT_EN
    // Accepted-word counter, wraps naturally at full scale.
    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) begin
            drain_cnt <= '0;
        end else if (pop) begin
            drain_cnt <= drain_cnt + {{(DRAIN_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            drain_cnt <= drain_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Testbench for fifo_rd_drain: FIFO read-port model feeding a scoreboard that
// is checked by an independent output monitor, plus directed scenario checks.
module tb_fifo_rd_drain;
    import fifo_pkg::*;

    localparam int DW = 8;

    logic          r_clk = 1'b0;
    logic          rrst = 1'b1;
    logic          m_ready = 1'b0;
    logic          gate_empty = 1'b0;
    logic          empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          r_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_DRAIN_CNT_EN
    logic [15:0]   drain_cnt;
`endif

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       rd_req = 1'b0;
    logic [7:0] mdl_word;
    logic [15:0] exp_drain = 16'd0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    int n_checks = 0;
    int n_errors = 0;

    int first_ren, first_val, first_hs, last_hs, nhs, nren, cyc_i;

    assign empty = gate_empty | (wr_cnt == rd_cnt);

    always #5 r_clk = ~r_clk;

    fifo_rd_drain #(.data_width(DW)) dut (
        .r_clk    (r_clk),
        .rrst     (rrst),
        .empty    (empty),
        .fifo_dout(fifo_dout),
        .r_en     (r_en),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
`ifdef FIFO_RD_DRAIN_CNT_EN
        ,
        .drain_cnt(drain_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO read-port model: data appears one cycle after the sampled r_en;
    // each word handed out becomes the next expected stream word.
    always @(posedge r_clk) begin
        if (rrst) begin
            exp_q.delete();
        end else if (rd_req && fifo_q.size() > 0) begin
            mdl_word = fifo_q.pop_front();
            fifo_dout <= mdl_word;
            exp_q.push_back(mdl_word);
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Output monitor: sampled mid-cycle, compares stream words to the scoreboard.
    always @(negedge r_clk) begin
        rd_req = r_en;
        if (r_en) begin
            check("ren_while_empty", 32'(empty), 32'd0);
        end
        if (rrst) begin
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_r_en", 32'(r_en), 32'd0);
            check("rst_m_data", 32'(m_data), 32'd0);
            exp_drain = 16'd0;
`ifdef FIFO_RD_DRAIN_CNT_EN
            check("rst_drain_cnt", 32'(drain_cnt), 32'd0);
`endif
        end else begin
`ifdef FIFO_RD_DRAIN_CNT_EN
            check("drain_cnt", 32'(drain_cnt), 32'(exp_drain));
`endif
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_word: got 0x%0h expected no word at %0t", m_data, $time);
                end else begin
                    check("order", 32'(m_data), 32'(exp_q.pop_front()));
                end
                exp_drain = exp_drain + 16'd1;
            end
        end
        prev_stall = m_valid && !m_ready && !rrst;
        prev_data  = m_data;
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        fifo_q.push_back(v);
        wr_cnt++;
    endtask

    task automatic drain(input int budget);
        int quiet;
        quiet = 0;
        m_ready = 1'b1;
        gate_empty = 1'b0;
        for (int i = 0; i < budget && quiet < 4; i++) begin
            tick();
            if (fifo_q.size() == 0 && !m_valid && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        check("drain_done", 32'(quiet >= 4), 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset with a preloaded FIFO: r_en must stay low despite empty=0.
        rrst = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) load(8'(i));
        repeat (2) @(negedge r_clk);
        check("rst_ren_nonempty", 32'(r_en), 32'd0);

        // Continuous drain: 8 words on consecutive cycles, 2-cycle first latency.
        @(posedge r_clk);
        #1;
        rrst = 1'b0;
        first_ren = -1; first_val = -1; first_hs = -1; last_hs = -1; nhs = 0;
        for (cyc_i = 0; cyc_i < 20; cyc_i++) begin
            @(negedge r_clk);
            if (r_en && first_ren < 0) first_ren = cyc_i;
            if (m_valid && first_val < 0) first_val = cyc_i;
            if (m_valid && m_ready) begin
                if (first_hs < 0) first_hs = cyc_i;
                last_hs = cyc_i;
                nhs++;
            end
        end
        check("first_latency", 32'(first_val - first_ren), 32'd2);
        check("burst_count", 32'(nhs), 32'd8);
        check("burst_span", 32'(last_hs - first_hs), 32'd7);
        drain(50);

        // Backpressure: two words, exactly two reads, buffer full and held.
        tick();
        m_ready = 1'b0;
        load(8'hA5);
        load(8'h5A);
        nren = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge r_clk);
            if (r_en) nren++;
        end
        check("bp_ren_pulses", 32'(nren), 32'd2);
        check("bp_state", 32'(dut.occ), 32'(OCC2));
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_head", 32'(m_data), 32'hA5);
        tick();
        load(8'h3C);
        nren = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge r_clk);
            if (r_en) nren++;
        end
        check("full_no_ren", 32'(nren), 32'd0);
        tick();
        m_ready = 1'b1;
        @(negedge r_clk);
        check("release_first", 32'(m_data), 32'hA5);
        tick();
        @(negedge r_clk);
        check("release_second", 32'(m_data), 32'h5A);
        drain(50);

        // Reset pulse mid-stream: outputs drop at once, remaining words still in order.
        for (int i = 0; i < 6; i++) load(8'(8'h10 + i));
        m_ready = 1'b1;
        repeat (3) tick();
        rrst = 1'b1;
        @(negedge r_clk);
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_ren", 32'(r_en), 32'd0);
        tick();
        tick();
        rrst = 1'b0;
        drain(60);

        // Empty flag toggling every cycle with random backpressure.
        for (int i = 0; i < 12; i++) load(8'(8'h30 + i));
        for (int i = 0; i < 60; i++) begin
            gate_empty = ~gate_empty;
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain(200);
        check("fifo_consumed", 32'(fifo_q.size()), 32'd0);

`ifdef FIFO_RD_DRAIN_CNT_EN
        // Counter wrap: 65537 accepted words leave drain_cnt at 1.
        tick();
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        for (int i = 0; i < 65537; i++) load(8'(i));
        drain(70000);
        check("cnt_wrap", 32'(drain_cnt), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
